// File: rtl/l2_pmem_adaptor.sv
// L2 line <-> memory burst adaptor: one LINE_WIDTH request becomes BEATS beats of
// BURST_WIDTH, with burst_resp acting as a per-beat accept/return strobe.
module l2_pmem_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pmem_read,
    input  logic                   pmem_write,
    input  logic [31:0]            pmem_address,
    input  logic [LINE_WIDTH-1:0]  pmem_wdata,
    output logic [LINE_WIDTH-1:0]  pmem_rdata,
    output logic                   pmem_resp,
    output logic                   burst_read,
    output logic                   burst_write,
    output logic [31:0]            burst_address,
    output logic [BURST_WIDTH-1:0] burst_wdata,
    input  logic [BURST_WIDTH-1:0] burst_rdata,
    input  logic                   burst_resp
);
    localparam int BEATS  = LINE_WIDTH / BURST_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [31:0]       OFF_MASK  = 32'((LINE_WIDTH / 8) - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, RESP} state_e;

    state_e                state_q, state_d;
    logic [BEAT_W-1:0]     beat_q, beat_d;
    logic [31:0]           addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wline_q, wline_d;
    logic [LINE_WIDTH-1:0] rline_q, rline_d;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        unique case (state_q)
            IDLE: begin
                // Write wins so a dirty victim is written back before its refill.
                if (pmem_write || pmem_read) begin
                    state_d = pmem_write ? WR_BURST : RD_BURST;
                    addr_d  = pmem_address & ~OFF_MASK;
                    beat_d  = '0;
                    if (pmem_write) wline_d = pmem_wdata;
                end
            end
            RD_BURST, WR_BURST: begin
                if (burst_resp) begin
                    if (state_q == RD_BURST)
                        rline_d[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH] = burst_rdata;
                    beat_d = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
        end
    end

    assign pmem_rdata    = rline_q;
    assign pmem_resp     = (state_q == RESP);
    assign burst_read    = (state_q == RD_BURST);
    assign burst_write   = (state_q == WR_BURST);
    assign burst_address = addr_q;
    assign burst_wdata   = wline_q[int'(beat_q)*BURST_WIDTH +: BURST_WIDTH];

endmodule

// File: tb/tb_l2_pmem_adaptor.sv
// Bench for l2_pmem_adaptor: cycle vectors for the basic read/write, hand sequences
// for stall/back-to-back/reset, and a random stress run against a line-level memory model.
module tb_l2_pmem_adaptor;
    localparam int LW = 256;
    localparam int BW = 64;
    localparam int BEATS = LW / BW;

    logic          clk, rst_n;
    logic          pmem_read, pmem_write;
    logic [31:0]   pmem_address;
    logic [LW-1:0] pmem_wdata, pmem_rdata;
    logic          pmem_resp, burst_read, burst_write, burst_resp;
    logic [31:0]   burst_address;
    logic [BW-1:0] burst_wdata, burst_rdata;

    l2_pmem_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
        .burst_read(burst_read), .burst_write(burst_write),
        .burst_address(burst_address), .burst_wdata(burst_wdata),
        .burst_rdata(burst_rdata), .burst_resp(burst_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_resp = 0;

    // Memory contents as L2 expects them, and as the memory side actually holds them.
    logic [LW-1:0] ref_mem  [logic [31:0]];
    logic [LW-1:0] phys_mem [logic [31:0]];

    typedef struct {
        logic          rd, wr;
        logic [31:0]   addr;
        logic [LW-1:0] wd;
        logic          bresp;
        logic [BW-1:0] brd;
        logic          e_brd, e_bwr, e_resp;
        logic [31:0]   e_addr;
        logic          chk_wd;
        logic [BW-1:0] e_wd;
        logic          chk_rd;
        logic [LW-1:0] e_rd;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] dflt(input logic [31:0] la);
        return {8{la ^ 32'hC0DE_0000}};
    endfunction

    function automatic logic [LW-1:0] ref_get(input logic [31:0] la);
        return ref_mem.exists(la) ? ref_mem[la] : dflt(la);
    endfunction

    function automatic logic [LW-1:0] phys_get(input logic [31:0] la);
        return phys_mem.exists(la) ? phys_mem[la] : dflt(la);
    endfunction

    function automatic logic [LW-1:0] rnd256();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [LW-1:0] wd, input logic bresp, input logic [BW-1:0] brd,
                                input logic e_brd, input logic e_bwr, input logic e_resp,
                                input logic [31:0] e_addr, input logic chk_wd, input logic [BW-1:0] e_wd,
                                input logic chk_rd, input logic [LW-1:0] e_rd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wd = wd; v.bresp = bresp; v.brd = brd;
        v.e_brd = e_brd; v.e_bwr = e_bwr; v.e_resp = e_resp; v.e_addr = e_addr;
        v.chk_wd = chk_wd; v.e_wd = e_wd; v.chk_rd = chk_rd; v.e_rd = e_rd;
        return v;
    endfunction

    // One L2 transaction, started in an IDLE cycle; returns in the cycle after pmem_resp.
    // lat = cycles from the request cycle to the pmem_resp cycle.
    task automatic run_req(input bit wr, input logic [31:0] a, input logic [LW-1:0] wd,
                           input int stall_pct, input bit noisy, output int lat);
        logic [31:0]   la;
        logic [LW-1:0] line, cap;
        int            beats, cyc;
        bit            done;
        la = a & ~32'h1F;
        line = wr ? wd : phys_get(la);
        cap = '0;
        beats = 0; cyc = 0; done = 0; lat = -1;
        pmem_read = !wr; pmem_write = wr; pmem_address = a; pmem_wdata = wd;
        burst_resp = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        burst_rdata = $urandom();
        while (!done) begin
            tick();
            cyc++;
            chk("rw_exclusive", LW'(burst_read & burst_write), '0);
            if (pmem_resp) begin
                n_resp++;
                lat = cyc;
                chk("beats_at_resp", LW'(beats), LW'(BEATS));
                if (wr) begin
                    phys_mem[la] = cap;
                    ref_mem[la] = wd;
                end else begin
                    chk("read_line", pmem_rdata, ref_get(la));
                end
                pmem_read = 0; pmem_write = 0;
                burst_resp = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
                tick();
                chk("resp_single_cycle", LW'(pmem_resp), '0);
                done = 1;
            end else if (burst_read || burst_write) begin
                chk("burst_dir", LW'(burst_write), LW'(wr));
                chk("burst_addr", LW'(burst_address), LW'(la));
                if (beats >= BEATS) begin
                    chk("extra_beat", LW'(beats), LW'(BEATS - 1));
                end else if (wr) begin
                    chk("burst_wdata", LW'(burst_wdata), LW'(wd[beats*BW +: BW]));
                end
                if (noisy && $urandom_range(0, 99) < 30) begin
                    pmem_read = 0; pmem_write = 0;
                    pmem_address = $urandom(); pmem_wdata = rnd256();
                end
                burst_resp = ($urandom_range(0, 99) >= stall_pct);
                burst_rdata = $urandom();
                if (burst_resp && beats < BEATS) begin
                    if (!wr) burst_rdata = line[beats*BW +: BW];
                    else cap[beats*BW +: BW] = burst_wdata;
                    beats++;
                end
            end else begin
                burst_resp = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (!done && cyc > 300) begin
                n_chk++; n_fail++;
                $display("FAIL req_timeout: got no pmem_resp within %0d cycles, required one", cyc);
                pmem_read = 0; pmem_write = 0; burst_resp = 0;
                done = 1;
            end
        end
    endtask

    initial begin
        logic [LW-1:0] rline, wline, exp_line, wb;
        logic [BW-1:0] b1, b2, b3, b4;
        logic [6:0]    pat;
        logic [31:0]   a;
        int            k, lat, r0;

        pmem_read = 0; pmem_write = 0; pmem_address = '0; pmem_wdata = '0;
        burst_resp = 0; burst_rdata = '0;
        rst_n = 1;
        #1 rst_n = 0;
        #2;
        chk("rst_pmem_resp", LW'(pmem_resp), '0);
        chk("rst_burst_read", LW'(burst_read), '0);
        chk("rst_burst_write", LW'(burst_write), '0);
        chk("rst_burst_address", LW'(burst_address), '0);
        chk("rst_burst_wdata", LW'(burst_wdata), '0);
        chk("rst_pmem_rdata", pmem_rdata, '0);
        tick(); tick();
        rst_n = 1;
        tick();

        b1 = 64'h1111_1111_1111_1111; b2 = 64'h2222_2222_2222_2222;
        b3 = 64'h3333_3333_3333_3333; b4 = 64'h4444_4444_4444_4444;
        rline = {b4, b3, b2, b1};
        wline = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                 64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
        vecs[0]  = mk(1, 0, 32'h0000_1234, '0, 0, '0, 0, 0, 0, 32'h0, 0, '0, 0, '0);
        vecs[1]  = mk(1, 0, 32'h0000_1234, '0, 1, b1, 1, 0, 0, 32'h1220, 0, '0, 0, '0);
        vecs[2]  = mk(1, 0, 32'h0000_1234, '0, 1, b2, 1, 0, 0, 32'h1220, 0, '0, 0, '0);
        vecs[3]  = mk(1, 0, 32'h0000_1234, '0, 1, b3, 1, 0, 0, 32'h1220, 0, '0, 0, '0);
        vecs[4]  = mk(1, 0, 32'h0000_1234, '0, 1, b4, 1, 0, 0, 32'h1220, 0, '0, 0, '0);
        vecs[5]  = mk(1, 0, 32'h0000_1234, '0, 0, '0, 0, 0, 1, 32'h1220, 0, '0, 1, rline);
        vecs[6]  = mk(0, 0, 32'h0000_0000, '0, 0, '0, 0, 0, 0, 32'h1220, 0, '0, 1, rline);
        vecs[7]  = mk(0, 1, 32'h0000_2000, wline, 0, '0, 0, 0, 0, 32'h1220, 0, '0, 0, '0);
        vecs[8]  = mk(0, 1, 32'h0000_2000, wline, 1, '0, 0, 1, 0, 32'h2000, 1, wline[63:0], 0, '0);
        vecs[9]  = mk(0, 1, 32'h0000_2000, wline, 1, '0, 0, 1, 0, 32'h2000, 1, wline[127:64], 0, '0);
        vecs[10] = mk(0, 1, 32'h0000_2000, wline, 1, '0, 0, 1, 0, 32'h2000, 1, wline[191:128], 0, '0);
        vecs[11] = mk(0, 1, 32'h0000_2000, wline, 1, '0, 0, 1, 0, 32'h2000, 1, wline[255:192], 0, '0);
        vecs[12] = mk(0, 1, 32'h0000_2000, wline, 0, '0, 0, 0, 1, 32'h2000, 0, '0, 1, rline);
        vecs[13] = mk(0, 0, 32'h0000_0000, '0, 0, '0, 0, 0, 0, 32'h2000, 0, '0, 1, rline);

        for (int i = 0; i < 14; i++) begin
            chk($sformatf("vec%0d_burst_read", i), LW'(burst_read), LW'(vecs[i].e_brd));
            chk($sformatf("vec%0d_burst_write", i), LW'(burst_write), LW'(vecs[i].e_bwr));
            chk($sformatf("vec%0d_pmem_resp", i), LW'(pmem_resp), LW'(vecs[i].e_resp));
            chk($sformatf("vec%0d_burst_address", i), LW'(burst_address), LW'(vecs[i].e_addr));
            if (vecs[i].chk_wd) chk($sformatf("vec%0d_burst_wdata", i), LW'(burst_wdata), LW'(vecs[i].e_wd));
            if (vecs[i].chk_rd) chk($sformatf("vec%0d_pmem_rdata", i), pmem_rdata, vecs[i].e_rd);
            pmem_read = vecs[i].rd; pmem_write = vecs[i].wr;
            pmem_address = vecs[i].addr; pmem_wdata = vecs[i].wd;
            burst_resp = vecs[i].bresp; burst_rdata = vecs[i].brd;
            tick();
        end

        // Stalled read: burst_resp pattern 1,0,0,1,1,0,1 (bit 0 first).
        pat = 7'b1011001;
        k = 0;
        exp_line = '0;
        pmem_read = 1; pmem_address = 32'h0000_0047; burst_resp = 0;
        tick();
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("stall%0d_burst_read", i), LW'(burst_read), LW'(1));
            chk($sformatf("stall%0d_burst_address", i), LW'(burst_address), LW'(32'h40));
            chk($sformatf("stall%0d_pmem_resp", i), LW'(pmem_resp), '0);
            burst_resp = pat[i];
            burst_rdata = $urandom();
            if (pat[i]) begin
                burst_rdata = {8{8'(8'hA0 + k)}};
                exp_line[k*BW +: BW] = burst_rdata;
                k++;
            end
            tick();
        end
        chk("stall_resp", LW'(pmem_resp), LW'(1));
        chk("stall_rdata", pmem_rdata, exp_line);
        pmem_read = 0; burst_resp = 0;
        tick();
        chk("stall_resp_drop", LW'(pmem_resp), '0);
        chk("stall_idle_read", LW'(burst_read), '0);

        // Write-back followed immediately by refill of the same line.
        r0 = n_resp;
        wb = rnd256();
        run_req(1, 32'h0001_0047, wb, 0, 0, lat);
        chk("wb_latency", LW'(lat), LW'(5));
        run_req(0, 32'h0001_0040, '0, 0, 0, lat);
        chk("refill_latency", LW'(lat), LW'(5));
        chk("wb_refill_resp_count", LW'(n_resp - r0), LW'(2));

        // Both requests high: write goes first; reset at beat 2 aborts it.
        pmem_read = 1; pmem_write = 1; pmem_address = 32'h0000_3000; pmem_wdata = rnd256();
        burst_resp = 0;
        tick();
        chk("both_burst_write", LW'(burst_write), LW'(1));
        chk("both_burst_read", LW'(burst_read), '0);
        burst_resp = 1;
        tick();
        tick();
        chk("both_beat2_write", LW'(burst_write), LW'(1));
        rst_n = 0;
        pmem_read = 0; pmem_write = 0; burst_resp = 0;
        #1;
        chk("mid_rst_burst_write", LW'(burst_write), '0);
        chk("mid_rst_burst_read", LW'(burst_read), '0);
        chk("mid_rst_pmem_resp", LW'(pmem_resp), '0);
        chk("mid_rst_burst_address", LW'(burst_address), '0);
        chk("mid_rst_burst_wdata", LW'(burst_wdata), '0);
        chk("mid_rst_pmem_rdata", pmem_rdata, '0);
        tick();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("post_rst%0d_no_resp", i), LW'(pmem_resp), '0);
        end
        run_req(1, 32'h0001_00A0, rnd256(), 0, 0, lat);
        chk("post_rst_latency", LW'(lat), LW'(5));
        run_req(0, 32'h0001_00A4, '0, 0, 0, lat);

        // Random stress over 8 lines with stalls, noise and mid-burst request changes.
        for (int n = 0; n < 80; n++) begin
            a = 32'h0001_0000 + 32'($urandom_range(0, 7) * 32) + 32'($urandom_range(0, 31));
            run_req(1'($urandom_range(0, 1)), a, rnd256(), $urandom_range(0, 60), 1, lat);
            pmem_read = 0; pmem_write = 0; burst_resp = 0;
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end
endmodule
